// File: rtl/decode_stage_if.sv
// Bundle of fetch, RegFile, write-back and ID/EX signals around the decode stage.
// slave  : the decode stage itself.
// master : the surrounding pipeline (fetch, RegFile, write-back, execute).
interface decode_stage_if;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic        inst_ready_o;
    logic [4:0]  rsR1_o;
    logic [4:0]  rsR2_o;
    logic [31:0] dataR1_i;
    logic [31:0] dataR2_i;
    logic        wbWEn_i;
    logic [4:0]  wbRd_i;
    logic [31:0] wbData_i;
    logic        flush_i;
    logic        ex_ready_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [31:0] ex_imm_o;
    logic [31:0] ex_rs1Data_o;
    logic [31:0] ex_rs2Data_o;
    logic [4:0]  ex_rd_o;
    logic [4:0]  ex_rs1_o;
    logic [4:0]  ex_rs2_o;
    logic [3:0]  ex_opClass_o;
    logic [2:0]  ex_funct3_o;
    logic        ex_funct7b5_o;
    logic        ex_regWEn_o;

    modport slave (
        input  inst_valid_i, inst_i, pc_i, dataR1_i, dataR2_i,
               wbWEn_i, wbRd_i, wbData_i, flush_i, ex_ready_i,
        output inst_ready_o, rsR1_o, rsR2_o, ex_valid_o, ex_pc_o, ex_imm_o,
               ex_rs1Data_o, ex_rs2Data_o, ex_rd_o, ex_rs1_o, ex_rs2_o,
               ex_opClass_o, ex_funct3_o, ex_funct7b5_o, ex_regWEn_o
    );

    modport master (
        output inst_valid_i, inst_i, pc_i, dataR1_i, dataR2_i,
               wbWEn_i, wbRd_i, wbData_i, flush_i, ex_ready_i,
        input  inst_ready_o, rsR1_o, rsR2_o, ex_valid_o, ex_pc_o, ex_imm_o,
               ex_rs1Data_o, ex_rs2Data_o, ex_rd_o, ex_rs1_o, ex_rs2_o,
               ex_opClass_o, ex_funct3_o, ex_funct7b5_o, ex_regWEn_o
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: opcode/immediate/register decode, write-back bypass,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    decode_stage_if.slave bus
);
    logic [XLEN-1:0] inst;
    logic [3:0]      dec_class;
    logic [XLEN-1:0] dec_imm;
    logic            dec_use_rs1;
    logic            dec_use_rs2;
    logic            dec_wen;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            hazard;
    logic            inst_ready;
    logic            accept;

    logic            ex_valid_reg;
    logic [XLEN-1:0] ex_pc_reg;
    logic [XLEN-1:0] ex_imm_reg;
    logic [4:0]      ex_rd_reg;
    logic [4:0]      ex_rs1_reg;
    logic [4:0]      ex_rs2_reg;
    logic [3:0]      ex_op_class_reg;
    logic [2:0]      ex_funct3_reg;
    logic            ex_funct7b5_reg;
    logic            ex_reg_wen_reg;

    // Per-operand views so both bypass paths share one description.
    logic [4:0]      rs_addr [2];
    logic [XLEN-1:0] rf_data [2];
    logic [4:0]      held_rs [2];
    logic [XLEN-1:0] ex_rs_data_reg [2];

    assign inst        = bus.inst_i;
    assign bus.rsR1_o  = inst[19:15];
    assign bus.rsR2_o  = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Opcode class, immediate selection and operand/destination usage.
    always_comb begin
        dec_class = 4'd15;
        case (inst[6:0])
            7'b0001111: dec_class = 4'd0;
            7'b0110111: dec_class = 4'd1;
            7'b0010111: dec_class = 4'd2;
            7'b1101111: dec_class = 4'd3;
            7'b1100111: dec_class = 4'd4;
            7'b1100011: dec_class = 4'd5;
            7'b0000011: dec_class = 4'd6;
            7'b0100011: dec_class = 4'd7;
            7'b0010011: dec_class = 4'd8;
            7'b0110011: dec_class = 4'd9;
            7'b1110011: dec_class = 4'd10;
            default:    dec_class = 4'd15;
        endcase

        dec_imm     = '0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_wen     = 1'b0;
        case (dec_class)
            4'd1, 4'd2: begin dec_imm = imm_u; dec_wen = 1'b1; end
            4'd3:       begin dec_imm = imm_j; dec_wen = 1'b1; end
            4'd4:       begin dec_imm = imm_i; dec_wen = 1'b1; dec_use_rs1 = 1'b1; end
            4'd5:       begin dec_imm = imm_b; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; end
            4'd6:       begin dec_imm = imm_i; dec_wen = 1'b1; dec_use_rs1 = 1'b1; end
            4'd7:       begin dec_imm = imm_s; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; end
            4'd8:       begin dec_imm = imm_i; dec_wen = 1'b1; dec_use_rs1 = 1'b1; end
            4'd9:       begin dec_wen = 1'b1; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; end
            4'd10:      begin dec_imm = imm_i; end
            default:    begin dec_imm = '0; end
        endcase

        // x0 as destination is never written, so it is reported as no write.
        if (inst[11:7] == 5'd0) begin
            dec_wen = 1'b0;
        end
        dec_rd  = dec_wen     ? inst[11:7]  : 5'd0;
        dec_rs1 = dec_use_rs1 ? inst[19:15] : 5'd0;
        dec_rs2 = dec_use_rs2 ? inst[24:20] : 5'd0;
    end

    // A held load whose rd feeds a used source of the incoming instruction
    // must be separated from it by one bubble. ex_rd_reg is already 0 when
    // the held instruction does not write, and unused sources are 0.
    assign hazard = ex_valid_reg && (ex_op_class_reg == 4'd6) && (ex_rd_reg != 5'd0) &&
                    ((dec_rs1 == ex_rd_reg) || (dec_rs2 == ex_rd_reg));

    assign inst_ready = !rst_i && (bus.flush_i ||
                        ((!ex_valid_reg || bus.ex_ready_i) && !hazard));
    assign accept     = bus.inst_valid_i && inst_ready;
    assign bus.inst_ready_o = inst_ready;

    assign rs_addr[0] = inst[19:15];
    assign rs_addr[1] = inst[24:20];
    assign rf_data[0] = bus.dataR1_i;
    assign rf_data[1] = bus.dataR2_i;
    assign held_rs[0] = ex_rs1_reg;
    assign held_rs[1] = ex_rs2_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic            cap_hit;
            logic            held_hit;
            logic [XLEN-1:0] cap_data;

            assign cap_hit  = bus.wbWEn_i && (bus.wbRd_i != 5'd0) && (bus.wbRd_i == rs_addr[gi]);
            assign held_hit = bus.wbWEn_i && (bus.wbRd_i != 5'd0) && (bus.wbRd_i == held_rs[gi]);
            assign cap_data = cap_hit ? bus.wbData_i : rf_data[gi];

            // Operand data: capture with bypass on accept, refresh while stalled.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ex_rs_data_reg[gi] <= '0;
                end else if (bus.flush_i) begin
                    ex_rs_data_reg[gi] <= ex_rs_data_reg[gi];
                end else if (accept) begin
                    ex_rs_data_reg[gi] <= cap_data;
                end else if (ex_valid_reg && !bus.ex_ready_i && held_hit) begin
                    ex_rs_data_reg[gi] <= bus.wbData_i;
                end
            end
        end
    endgenerate

    // ID/EX control and decoded fields: reset > flush > accept > bubble > hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_reg    <= 1'b0;
            ex_pc_reg       <= '0;
            ex_imm_reg      <= '0;
            ex_rd_reg       <= '0;
            ex_rs1_reg      <= '0;
            ex_rs2_reg      <= '0;
            ex_op_class_reg <= '0;
            ex_funct3_reg   <= '0;
            ex_funct7b5_reg <= 1'b0;
            ex_reg_wen_reg  <= 1'b0;
        end else if (bus.flush_i) begin
            ex_valid_reg <= 1'b0;
        end else if (accept) begin
            ex_valid_reg    <= 1'b1;
            ex_pc_reg       <= bus.pc_i;
            ex_imm_reg      <= dec_imm;
            ex_rd_reg       <= dec_rd;
            ex_rs1_reg      <= dec_rs1;
            ex_rs2_reg      <= dec_rs2;
            ex_op_class_reg <= dec_class;
            ex_funct3_reg   <= inst[14:12];
            ex_funct7b5_reg <= inst[30];
            ex_reg_wen_reg  <= dec_wen;
        end else if (bus.ex_ready_i) begin
            ex_valid_reg <= 1'b0;
        end
    end

    assign bus.ex_valid_o    = ex_valid_reg;
    assign bus.ex_pc_o       = ex_pc_reg;
    assign bus.ex_imm_o      = ex_imm_reg;
    assign bus.ex_rs1Data_o  = ex_rs_data_reg[0];
    assign bus.ex_rs2Data_o  = ex_rs_data_reg[1];
    assign bus.ex_rd_o       = ex_rd_reg;
    assign bus.ex_rs1_o      = ex_rs1_reg;
    assign bus.ex_rs2_o      = ex_rs2_reg;
    assign bus.ex_opClass_o  = ex_op_class_reg;
    assign bus.ex_funct3_o   = ex_funct3_reg;
    assign bus.ex_funct7b5_o = ex_funct7b5_reg;
    assign bus.ex_regWEn_o   = ex_reg_wen_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, hand-written pipeline
// sequences and a randomized run against a behavioural pipeline model.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus();

    decode_stage #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] rf [32];
    assign bus.dataR1_i = (bus.rsR1_o == 5'd0) ? 32'd0 : rf[bus.rsR1_o];
    assign bus.dataR2_i = (bus.rsR2_o == 5'd0) ? 32'd0 : rf[bus.rsR2_o];

    int checks = 0;
    int errors = 0;

    // Class number is the index in this table; anything else is class 15.
    logic [6:0] opc_tab [11] = '{7'h0F, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

    typedef struct packed {
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wen;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic        wen;
    } ms_t;

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wen;
    } vec_t;

    ms_t  m;
    vec_t tab [13];

    task automatic chk(input string nm, input logic [151:0] act, input logic [151:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Decode from the instruction-set rules using plain integer arithmetic.
    function automatic dec_t ref_dec(input logic [31:0] inst);
        dec_t d;
        int   c;
        int   s;
        int   v;
        d = '0;
        c = 15;
        if (inst[1:0] == 2'b11)
            for (int k = 0; k < 11; k++)
                if (inst[6:0] == opc_tab[k]) c = k;
        d.cls = 4'(c);
        s = int'($signed(inst)) >>> 20;
        v = 0;
        case (c)
            4, 6, 8, 10: v = s;
            7: v = (s & ~32'h1F) | int'(inst[11:7]);
            5: v = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 +
                   int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
            1, 2: v = int'(inst & 32'hFFFFF000);
            3: v = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096 +
                   int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
            default: v = 0;
        endcase
        d.imm = 32'(v);
        d.wen = (c inside {1, 2, 3, 4, 6, 8, 9}) && (inst[11:7] != 5'd0);
        d.rd  = d.wen ? inst[11:7] : 5'd0;
        d.rs1 = (c >= 4 && c <= 9) ? inst[19:15] : 5'd0;
        d.rs2 = (c inside {5, 7, 9}) ? inst[24:20] : 5'd0;
        return d;
    endfunction

    function automatic logic [31:0] wb_or_rf(input logic [4:0] a);
        if (bus.wbWEn_i && bus.wbRd_i != 5'd0 && bus.wbRd_i == a) return bus.wbData_i;
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    function automatic logic [151:0] dut_fields();
        return {bus.ex_pc_o, bus.ex_imm_o, bus.ex_rs1Data_o, bus.ex_rs2Data_o,
                bus.ex_rd_o, bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_opClass_o,
                bus.ex_funct3_o, bus.ex_funct7b5_o, bus.ex_regWEn_o};
    endfunction

    function automatic logic [151:0] model_fields(input ms_t x);
        return {x.pc, x.imm, x.d1, x.d2, x.rd, x.rs1, x.rs2, x.cls, x.f3, x.f7, x.wen};
    endfunction

    task automatic present(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                           input logic exr, input logic fl);
        @(negedge clk);
        bus.inst_valid_i = v;
        bus.inst_i       = inst;
        bus.pc_i         = pc;
        bus.ex_ready_i   = exr;
        bus.flush_i      = fl;
        bus.wbWEn_i      = 1'b0;
        bus.wbRd_i       = 5'd0;
        bus.wbData_i     = 32'd0;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.wbWEn_i  = en;
        bus.wbRd_i   = rd;
        bus.wbData_i = data;
    endtask

    // One clock of the pipeline: predict, check handshake, clock, check register.
    task automatic step();
        dec_t d;
        ms_t  n;
        logic hz, rdy, acc;
        #1;
        d   = ref_dec(bus.inst_i);
        hz  = m.v && m.cls == 4'd6 && m.rd != 5'd0 && (d.rs1 == m.rd || d.rs2 == m.rd);
        rdy = bus.flush_i || ((!m.v || bus.ex_ready_i) && !hz);
        chk("inst_ready", 152'(bus.inst_ready_o), 152'(rdy));
        chk("rsR", 152'({bus.rsR1_o, bus.rsR2_o}), 152'({bus.inst_i[19:15], bus.inst_i[24:20]}));
        acc = bus.inst_valid_i && rdy;
        n = m;
        if (bus.flush_i) begin
            n.v = 1'b0;
        end else if (acc) begin
            n.v = 1'b1;      n.pc = bus.pc_i;  n.imm = d.imm;
            n.d1 = wb_or_rf(bus.inst_i[19:15]);
            n.d2 = wb_or_rf(bus.inst_i[24:20]);
            n.rd = d.rd;     n.rs1 = d.rs1;    n.rs2 = d.rs2;  n.cls = d.cls;
            n.f3 = bus.inst_i[14:12];          n.f7 = bus.inst_i[30];  n.wen = d.wen;
        end else if (bus.ex_ready_i) begin
            n.v = 1'b0;
        end else if (m.v) begin
            if (bus.wbWEn_i && bus.wbRd_i != 5'd0 && bus.wbRd_i == m.rs1) n.d1 = bus.wbData_i;
            if (bus.wbWEn_i && bus.wbRd_i != 5'd0 && bus.wbRd_i == m.rs2) n.d2 = bus.wbData_i;
        end
        @(posedge clk);
        if (bus.wbWEn_i && bus.wbRd_i != 5'd0) rf[bus.wbRd_i] = bus.wbData_i;
        m = n;
        #1;
        chk("ex_valid", 152'(bus.ex_valid_o), 152'(m.v));
        if (m.v) chk("ex_fields", dut_fields(), model_fields(m));
        $display("t=%0t v=%0b inst=%h rdy=%0b flush=%0b exr=%0b -> ex_valid=%0b cls=%0d rd=%0d",
                 $time, bus.inst_valid_i, bus.inst_i, rdy, bus.flush_i, bus.ex_ready_i,
                 bus.ex_valid_o, bus.ex_opClass_o, bus.ex_rd_o);
    endtask

    initial begin
        logic [31:0] r;
        int          k;

        tab[0]  = '{32'hFFF00293, 4'd8,  32'hFFFFFFFF, 5'd5, 5'd0, 5'd0, 1'b1}; // addi x5,x0,-1
        tab[1]  = '{32'h0000A303, 4'd6,  32'h00000000, 5'd6, 5'd1, 5'd0, 1'b1}; // lw x6,0(x1)
        tab[2]  = '{32'h00318233, 4'd9,  32'h00000000, 5'd4, 5'd3, 5'd3, 1'b1}; // add x4,x3,x3
        tab[3]  = '{32'h0020A423, 4'd7,  32'h00000008, 5'd0, 5'd1, 5'd2, 1'b0}; // sw x2,8(x1)
        tab[4]  = '{32'hFE000EE3, 4'd5,  32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 1'b0}; // beq x0,x0,-4
        tab[5]  = '{32'h123450B7, 4'd1,  32'h12345000, 5'd1, 5'd0, 5'd0, 1'b1}; // lui x1
        tab[6]  = '{32'h008000EF, 4'd3,  32'h00000008, 5'd1, 5'd0, 5'd0, 1'b1}; // jal x1,+8
        tab[7]  = '{32'h00001017, 4'd2,  32'h00001000, 5'd0, 5'd0, 5'd0, 1'b0}; // auipc x0
        tab[8]  = '{32'h00008067, 4'd4,  32'h00000000, 5'd0, 5'd1, 5'd0, 1'b0}; // jalr x0,0(x1)
        tab[9]  = '{32'h00000073, 4'd10, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0}; // ecall
        tab[10] = '{32'h0FF0000F, 4'd0,  32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0}; // fence
        tab[11] = '{32'hFFFFFFFF, 4'd15, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0}; // illegal
        tab[12] = '{32'h00000010, 4'd15, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0}; // inst[1:0]!=11

        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'(i) * 32'h01010101;
        rf[3] = 32'h11;
        m = '0;
        rst = 1'b1;
        bus.inst_valid_i = 1'b0; bus.inst_i = 32'd0; bus.pc_i = 32'd0;
        bus.ex_ready_i = 1'b0;   bus.flush_i = 1'b0;
        bus.wbWEn_i = 1'b0;      bus.wbRd_i = 5'd0;  bus.wbData_i = 32'd0;

        // Reset state.
        @(negedge clk); #1;
        chk("reset_valid", 152'(bus.ex_valid_o), 152'(0));
        chk("reset_fields", dut_fields(), 152'(0));
        chk("reset_ready", 152'(bus.inst_ready_o), 152'(0));
        @(negedge clk);
        rst = 1'b0;

        // Decode vector table, one accept per cycle.
        for (int i = 0; i < 13; i++) begin
            present(1'b1, tab[i].inst, 32'h1000 + 32'(i) * 4, 1'b1, 1'b0);
            step();
            chk($sformatf("table%0d", i),
                152'({bus.ex_valid_o, bus.ex_opClass_o, bus.ex_imm_o, bus.ex_rd_o,
                      bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_regWEn_o}),
                152'({1'b1, tab[i].cls, tab[i].imm, tab[i].rd, tab[i].rs1, tab[i].rs2, tab[i].wen}));
        end

        // addi x5,x0,-1 at pc 0x100.
        present(1'b1, 32'hFFF00293, 32'h100, 1'b1, 1'b0);
        step();
        chk("addi", 152'({bus.ex_valid_o, bus.ex_opClass_o, bus.ex_imm_o, bus.ex_rd_o,
                          bus.ex_regWEn_o, bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_pc_o}),
                    152'({1'b1, 4'd8, 32'hFFFFFFFF, 5'd5, 1'b1, 5'd0, 5'd0, 32'h100}));

        // Same-cycle write-back of x3 bypasses the stale RegFile value.
        rf[3] = 32'h11;
        present(1'b1, 32'h00318233, 32'h104, 1'b1, 1'b0);
        set_wb(1'b1, 5'd3, 32'h22);
        step();
        chk("bypass", 152'({bus.ex_rs1Data_o, bus.ex_rs2Data_o}), 152'({32'h22, 32'h22}));

        // Load-use: one bubble, then the dependent add goes through.
        present(1'b1, 32'h0000A303, 32'h108, 1'b1, 1'b0);
        step();
        present(1'b1, 32'h002303B3, 32'h10C, 1'b1, 1'b0);
        #1 chk("loaduse_stall", 152'(bus.inst_ready_o), 152'(0));
        step();
        chk("loaduse_bubble", 152'(bus.ex_valid_o), 152'(0));
        present(1'b1, 32'h002303B3, 32'h10C, 1'b1, 1'b0);
        #1 chk("loaduse_release", 152'(bus.inst_ready_o), 152'(1));
        step();
        chk("loaduse_add", 152'({bus.ex_valid_o, bus.ex_rd_o, bus.ex_pc_o}),
                           152'({1'b1, 5'd7, 32'h10C}));

        // Stall refresh: hold add x4,x3,x3 while x3 is written back.
        present(1'b1, 32'h00318233, 32'h110, 1'b1, 1'b0);
        step();
        for (int c = 1; c <= 3; c++) begin
            present(1'b1, 32'hFFF00293, 32'h114, 1'b0, 1'b0);
            if (c == 2) set_wb(1'b1, 5'd3, 32'h55);
            #1 chk($sformatf("stall_ready%0d", c), 152'(bus.inst_ready_o), 152'(0));
            step();
        end
        chk("stall_refresh", 152'({bus.ex_rs1Data_o, bus.ex_rs2Data_o}), 152'({32'h55, 32'h55}));
        chk("stall_hold", 152'({bus.ex_valid_o, bus.ex_pc_o, bus.ex_rd_o, bus.ex_opClass_o}),
                          152'({1'b1, 32'h110, 5'd4, 4'd9}));

        // Flush during the stall, then an illegal instruction passes through.
        present(1'b1, 32'hFFF00293, 32'h118, 1'b0, 1'b1);
        step();
        chk("flush", 152'(bus.ex_valid_o), 152'(0));
        present(1'b1, 32'hFFFFFFFF, 32'h11C, 1'b0, 1'b0);
        step();
        chk("illegal", 152'({bus.ex_valid_o, bus.ex_opClass_o, bus.ex_regWEn_o}),
                       152'({1'b1, 4'd15, 1'b0}));

        // Asynchronous reset while valid; first accept right after release.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_valid", 152'(bus.ex_valid_o), 152'(0));
        chk("midreset_fields", dut_fields(), 152'(0));
        chk("midreset_ready", 152'(bus.inst_ready_o), 152'(0));
        m = '0;
        @(negedge clk);
        rst = 1'b0;
        bus.inst_valid_i = 1'b1; bus.inst_i = 32'h00318233; bus.pc_i = 32'h200;
        bus.ex_ready_i = 1'b0;   bus.flush_i = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            k = $urandom_range(0, 11);
            if (k < 11) r[6:0] = opc_tab[k];
            r[11:7]  = 5'($urandom_range(0, 7));
            r[19:15] = 5'($urandom_range(0, 7));
            r[24:20] = 5'($urandom_range(0, 7));
            present(1'b1, r, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
            bus.inst_valid_i = ($urandom % 4) != 0;
            set_wb(($urandom % 2) == 1, 5'($urandom_range(0, 7)), $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
